// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: owners, FSM states, length codes, IO map.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_PF   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    LEN_ONE  = 3'd1,
    LEN_TWO  = 3'd2,
    LEN_FOUR = 3'd4
  } len_e;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: LS > IF > PF, except a starved IF beats LS.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_if_elig,
  input  logic   i_ls_elig,
  input  logic   i_pf_elig,
  input  logic   i_starved,
  output owner_e o_win
);

  always_comb begin
    o_win = OWN_NONE;
    if (i_if_elig && i_starved) o_win = OWN_IF;
    else if (i_ls_elig)         o_win = OWN_LS;
    else if (i_if_elig)         o_win = OWN_IF;
    else if (i_pf_elig)         o_win = OWN_PF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-serial memory controller between fetch, load/store and prefetch.
// Grant held until controller done; flushed fetch traffic drains silently.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iIO_buffer_full,
  input  logic        iFlush,
  input  logic        iIF_req,
  input  logic [31:0] iIF_addr,
  output logic        oIF_done,
  output logic [31:0] oIF_dt,
  input  logic        iLS_req,
  input  logic        iLS_wr,
  input  logic [2:0]  iLS_len,
  input  logic [31:0] iLS_addr,
  input  logic [31:0] iLS_dt,
  output logic        oLS_done,
  output logic [31:0] oLS_dt,
  input  logic        iPF_req,
  input  logic [31:0] iPF_addr,
  output logic        oPF_done,
  output logic [31:0] oPF_dt,
  output logic        oMC_en,
  output logic        oMC_wr,
  output logic [2:0]  oMC_len,
  output logic [31:0] oMC_addr,
  output logic [31:0] oMC_dt,
  input  logic        iMC_done,
  input  logic [31:0] iMC_dt,
  output logic [1:0]  oGrant
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_e        r_state;
  owner_e        r_grant;
  logic [CW-1:0] r_cnt;
  logic          r_mc_en, r_mc_wr;
  logic [2:0]    r_mc_len;
  logic [31:0]   r_mc_addr, r_mc_dt;
  logic          r_if_done, r_ls_done, r_pf_done;
  logic [31:0]   r_if_dt, r_ls_dt, r_pf_dt;

  logic   w_ls_elig, w_if_elig, w_pf_elig, w_starved, w_fetch_own;
  owner_e w_win;

  // A store into a full IO buffer stays pending rather than blocking the controller.
  assign w_ls_elig   = iLS_req & ~(iLS_wr & is_io(iLS_addr, IO_BASE) & iIO_buffer_full);
  assign w_if_elig   = iIF_req & ~iFlush;
  assign w_pf_elig   = iPF_req & ~iFlush;
  assign w_starved   = (r_cnt == CW'(STARVE_LIMIT));
  assign w_fetch_own = (r_grant == OWN_IF) || (r_grant == OWN_PF);

  mem_arb_pick u_pick (
    .i_if_elig (w_if_elig),
    .i_ls_elig (w_ls_elig),
    .i_pf_elig (w_pf_elig),
    .i_starved (w_starved),
    .o_win     (w_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= OWN_NONE;
      r_cnt     <= '0;
      r_mc_en   <= 1'b0;
      r_mc_wr   <= 1'b0;
      r_mc_len  <= '0;
      r_mc_addr <= '0;
      r_mc_dt   <= '0;
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      r_pf_done <= 1'b0;
      r_if_dt   <= '0;
      r_ls_dt   <= '0;
      r_pf_dt   <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      r_pf_done <= 1'b0;
      if (rdy) begin
        case (r_state)
          ST_IDLE: begin
            if (w_win != OWN_NONE) begin
              r_state <= ST_BUSY;
              r_grant <= w_win;
              r_mc_en <= 1'b1;
              if (w_win == OWN_LS) begin
                r_mc_wr   <= iLS_wr;
                r_mc_len  <= iLS_len;
                r_mc_addr <= iLS_addr;
                r_mc_dt   <= iLS_dt;
              end else begin
                r_mc_wr   <= 1'b0;
                r_mc_len  <= LEN_FOUR;
                r_mc_addr <= (w_win == OWN_IF) ? iIF_addr : iPF_addr;
                r_mc_dt   <= '0;
              end
              if (w_win == OWN_IF)
                r_cnt <= '0;
              else if (w_win == OWN_LS && iIF_req && !w_starved)
                r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_BUSY: begin
            if (iMC_done) begin
              r_state <= ST_IDLE;
              r_grant <= OWN_NONE;
              r_mc_en <= 1'b0;
              // A flush landing on the done cycle still cancels fetch-side data.
              if (!(iFlush && w_fetch_own)) begin
                case (r_grant)
                  OWN_IF:  begin r_if_done <= 1'b1; r_if_dt <= iMC_dt; end
                  OWN_LS:  begin r_ls_done <= 1'b1; r_ls_dt <= iMC_dt; end
                  OWN_PF:  begin r_pf_done <= 1'b1; r_pf_dt <= iMC_dt; end
                  default: ;
                endcase
              end
            end else if (iFlush && w_fetch_own) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (iMC_done) begin
              r_state <= ST_IDLE;
              r_grant <= OWN_NONE;
              r_mc_en <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign oIF_done = r_if_done;
  assign oIF_dt   = r_if_dt;
  assign oLS_done = r_ls_done;
  assign oLS_dt   = r_ls_dt;
  assign oPF_done = r_pf_done;
  assign oPF_dt   = r_pf_dt;
  assign oMC_en   = r_mc_en;
  assign oMC_wr   = r_mc_wr;
  assign oMC_len  = r_mc_len;
  assign oMC_addr = r_mc_addr;
  assign oMC_dt   = r_mc_dt;
  assign oGrant   = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level owner model.
module tb_mem_arbiter;

  logic        clk, rst, rdy, iIO_buffer_full, iFlush;
  logic        iIF_req, iLS_req, iLS_wr, iPF_req, iMC_done;
  logic [2:0]  iLS_len;
  logic [31:0] iIF_addr, iLS_addr, iLS_dt, iPF_addr, iMC_dt;
  logic        oIF_done, oLS_done, oPF_done, oMC_en, oMC_wr;
  logic [31:0] oIF_dt, oLS_dt, oPF_dt, oMC_addr, oMC_dt;
  logic [2:0]  oMC_len;
  logic [1:0]  oGrant;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iIO_buffer_full(iIO_buffer_full), .iFlush(iFlush),
    .iIF_req(iIF_req), .iIF_addr(iIF_addr), .oIF_done(oIF_done), .oIF_dt(oIF_dt),
    .iLS_req(iLS_req), .iLS_wr(iLS_wr), .iLS_len(iLS_len), .iLS_addr(iLS_addr),
    .iLS_dt(iLS_dt), .oLS_done(oLS_done), .oLS_dt(oLS_dt),
    .iPF_req(iPF_req), .iPF_addr(iPF_addr), .oPF_done(oPF_done), .oPF_dt(oPF_dt),
    .oMC_en(oMC_en), .oMC_wr(oMC_wr), .oMC_len(oMC_len), .oMC_addr(oMC_addr),
    .oMC_dt(oMC_dt), .iMC_done(iMC_done), .iMC_dt(iMC_dt), .oGrant(oGrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the controller, whether its result was cancelled, and what was issued.
  int          m_owner;
  bit          m_cancel;
  int          m_wins_ls;
  logic [3:1]  m_done;
  logic [31:0] m_dt [1:3];
  logic        m_wr;
  logic [2:0]  m_len;
  logic [31:0] m_addr, m_mdt;

  always @(posedge clk or negedge rst) begin : model
    bit ls_ok, if_ok, pf_ok;
    int win;
    if (!rst) begin
      m_owner <= 0; m_cancel <= 0; m_wins_ls <= 0; m_done <= '0;
      m_dt[1] <= '0; m_dt[2] <= '0; m_dt[3] <= '0;
      m_wr <= 0; m_len <= '0; m_addr <= '0; m_mdt <= '0;
    end else begin
      m_done <= '0;
      if (rdy) begin
        if (m_owner == 0) begin
          ls_ok = iLS_req && !(iLS_wr && iLS_addr >= 32'h0003_0000 && iIO_buffer_full);
          if_ok = iIF_req && !iFlush;
          pf_ok = iPF_req && !iFlush;
          win = 0;
          if (if_ok && m_wins_ls == 4) win = 1;
          else if (ls_ok) win = 2;
          else if (if_ok) win = 1;
          else if (pf_ok) win = 3;
          m_owner  <= win;
          m_cancel <= 0;
          if (win == 2) begin
            m_wr <= iLS_wr; m_len <= iLS_len; m_addr <= iLS_addr; m_mdt <= iLS_dt;
            if (iIF_req && m_wins_ls < 4) m_wins_ls <= m_wins_ls + 1;
          end else if (win != 0) begin
            m_wr <= 0; m_len <= 3'd4; m_mdt <= '0;
            m_addr <= (win == 1) ? iIF_addr : iPF_addr;
            if (win == 1) m_wins_ls <= 0;
          end
        end else if (iMC_done) begin
          if (!m_cancel && !(iFlush && m_owner != 2)) begin
            m_done[m_owner] <= 1'b1;
            m_dt[m_owner]   <= iMC_dt;
          end
          m_owner <= 0;
        end else if (iFlush && m_owner != 2) begin
          m_cancel <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("grant",   32'(oGrant),   32'(m_owner));
    chk("mc_en",   32'(oMC_en),   32'(m_owner != 0));
    chk("if_done", 32'(oIF_done), 32'(m_done[1]));
    chk("ls_done", 32'(oLS_done), 32'(m_done[2]));
    chk("pf_done", 32'(oPF_done), 32'(m_done[3]));
    chk("if_dt", oIF_dt, m_dt[1]);
    chk("ls_dt", oLS_dt, m_dt[2]);
    chk("pf_dt", oPF_dt, m_dt[3]);
    if (m_owner != 0) begin
      chk("mc_wr",   32'(oMC_wr),  32'(m_wr));
      chk("mc_len",  32'(oMC_len), 32'(m_len));
      chk("mc_addr", oMC_addr, m_addr);
      if (m_wr) chk("mc_dt", oMC_dt, m_mdt);
    end
  end

  task automatic cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    for (int k = 0; k < 30 && oGrant == 2'd0; k++) cycle();
    chk("wait_grant", 32'(oGrant != 2'd0), 32'd1);
    g = oGrant;
  endtask

  task automatic finish_access(input logic [31:0] dt);
    iMC_dt = dt; iMC_done = 1'b1;
    cycle();
    iMC_done = 1'b0;
  endtask

  logic [1:0] gr;
  int exp_order [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    rst = 0; rdy = 1; iIO_buffer_full = 0; iFlush = 0;
    iIF_req = 0; iIF_addr = 0; iLS_req = 0; iLS_wr = 0; iLS_len = 3'd4;
    iLS_addr = 0; iLS_dt = 0; iPF_req = 0; iPF_addr = 0; iMC_done = 0; iMC_dt = 0;
    cycle(); cycle();
    chk("rst_grant", 32'(oGrant), 0);
    chk("rst_en", 32'(oMC_en), 0);
    rst = 1;
    cycle();

    // Single IF fetch, done on the fifth cycle.
    iIF_req = 1; iIF_addr = 32'h100;
    cycle();
    iIF_req = 0;
    chk("if_len", 32'(oMC_len), 32'd4);
    chk("if_addr", oMC_addr, 32'h100);
    for (int k = 0; k < 4; k++) begin
      chk("if_en_held", 32'(oMC_en), 1);
      cycle();
    end
    chk("if_en_held", 32'(oMC_en), 1);
    finish_access(32'hDEADBEEF);
    chk("if_en_drop", 32'(oMC_en), 0);
    chk("if_done_pulse", 32'(oIF_done), 1);
    chk("if_dt_val", oIF_dt, 32'hDEADBEEF);
    chk("if_grant_clr", 32'(oGrant), 0);
    cycle();
    chk("if_done_once", 32'(oIF_done), 0);

    // Contention with starvation relief; PF also requesting.
    iIF_req = 1; iIF_addr = 32'h400; iPF_req = 1; iPF_addr = 32'h800;
    iLS_req = 1; iLS_wr = 0; iLS_addr = 32'h80; iLS_len = 3'd2;
    for (int g = 0; g < 10; g++) begin
      wait_grant(gr);
      chk("starve_order", 32'(gr), 32'(exp_order[g]));
      finish_access($urandom);
    end
    iIF_req = 0; iPF_req = 0; iLS_req = 0;

    // IO store held back by a full buffer.
    iLS_req = 1; iLS_wr = 1; iLS_addr = 32'h0003_0000; iLS_dt = 32'hA5A51234; iLS_len = 3'd4;
    iIO_buffer_full = 1; iIF_req = 1; iIF_addr = 32'h200;
    wait_grant(gr);
    chk("io_if_first", 32'(gr), 1);
    iIF_req = 0;
    finish_access(32'h1);
    iIO_buffer_full = 0;
    wait_grant(gr);
    chk("io_ls_grant", 32'(gr), 2);
    chk("io_ls_wr", 32'(oMC_wr), 1);
    chk("io_ls_dt", oMC_dt, 32'hA5A51234);
    iLS_req = 0; iLS_wr = 0;
    finish_access(32'h2);

    // Flush mid-fetch drains silently, then LS proceeds.
    iIF_req = 1; iIF_addr = 32'h500;
    wait_grant(gr);
    iIF_req = 0;
    cycle(); cycle();
    iFlush = 1; cycle(); iFlush = 0;
    chk("drain_en", 32'(oMC_en), 1);
    cycle();
    chk("drain_en2", 32'(oMC_en), 1);
    iLS_req = 1; iLS_addr = 32'h90; iLS_len = 3'd1;
    finish_access(32'h11112222);
    chk("drain_no_done", 32'(oIF_done), 0);
    chk("drain_en_drop", 32'(oMC_en), 0);
    wait_grant(gr);
    chk("after_drain_ls", 32'(gr), 2);
    iLS_req = 0;
    finish_access(32'h77);
    chk("after_drain_ls_dt", oLS_dt, 32'h77);

    // Flush coincident with done.
    iIF_req = 1; iIF_addr = 32'h540;
    wait_grant(gr);
    iIF_req = 0;
    cycle();
    iFlush = 1;
    finish_access(32'h3333);
    iFlush = 0;
    chk("flushdone_no_done", 32'(oIF_done), 0);
    chk("flushdone_grant", 32'(oGrant), 0);

    // rdy stall while busy.
    iLS_req = 1; iLS_wr = 0; iLS_addr = 32'hC0; iLS_len = 3'd4;
    wait_grant(gr);
    iLS_req = 0; iLS_addr = 32'hFFF0;
    rdy = 0; iMC_done = 1; iMC_dt = 32'h5555;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_en", 32'(oMC_en), 1);
      chk("stall_addr", oMC_addr, 32'hC0);
      chk("stall_done", 32'(oLS_done), 0);
    end
    rdy = 1; iMC_dt = 32'hCAFEF00D;
    cycle();
    iMC_done = 0;
    chk("stall_release_done", 32'(oLS_done), 1);
    chk("stall_release_dt", oLS_dt, 32'hCAFEF00D);
    cycle();
    chk("stall_single_pulse", 32'(oLS_done), 0);

    // Asynchronous reset mid-access.
    iIF_req = 1; iIF_addr = 32'h600;
    wait_grant(gr);
    iIF_req = 0;
    cycle();
    #1 rst = 0;
    #1;
    chk("arst_en", 32'(oMC_en), 0);
    chk("arst_grant", 32'(oGrant), 0);
    chk("arst_if_dt", oIF_dt, 0);
    cycle();
    rst = 1;
    iLS_req = 1; iLS_addr = 32'h44;
    wait_grant(gr);
    chk("post_rst_grant", 32'(gr), 2);
    iLS_req = 0;
    finish_access(32'h9);

    // Randomised traffic with a responsive controller.
    for (int c = 0; c < 4000; c++) begin
      rdy             = ($urandom % 10) != 0;
      iFlush          = ($urandom % 12) == 0;
      iIO_buffer_full = ($urandom % 3) == 0;
      iIF_req         = $urandom % 2;
      iIF_addr        = $urandom & 32'h0000_FFFC;
      iPF_req         = ($urandom % 3) == 0;
      iPF_addr        = $urandom & 32'h0000_FFFC;
      iLS_req         = $urandom % 2;
      iLS_wr          = $urandom % 2;
      iLS_addr        = ($urandom % 2) ? (32'h0003_0000 + ($urandom % 64)) : ($urandom & 32'h0000_FFFF);
      case ($urandom % 3)
        0:       iLS_len = 3'd1;
        1:       iLS_len = 3'd2;
        default: iLS_len = 3'd4;
      endcase
      iLS_dt   = $urandom;
      iMC_dt   = $urandom;
      iMC_done = oMC_en ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
      cycle();
    end
    iIF_req = 0; iLS_req = 0; iPF_req = 0; iMC_done = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Schedules the single byte-serial memory controller between three requesters: instruction fetch (IF), load/store buffer (LS) and instruction prefetcher (PF).
- Holds one grant until the controller reports done, then returns data and a done pulse to the owning requester.
- Handles branch-flush cancellation of fetch traffic, IO-store back-pressure and fetch-starvation avoidance.
- Sits between the front-end/LSB and the memory controller.

Parameters:
- STARVE_LIMIT, 4, number of consecutive arbitration wins by LS over a waiting IF before IF is forced to win.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are IO space.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rdy  input  1  global ready; 0 freezes the arbiter.
- iIO_buffer_full  input  1  IO output buffer full.
- iFlush  input  1  branch mispredict; cancels IF/PF traffic.
- iIF_req  input  1  fetch request (4-byte read).
- iIF_addr  input  32  fetch address.
- oIF_done  output  1  one-cycle fetch-complete pulse.
- oIF_dt  output  32  fetched word.
- iLS_req  input  1  load/store request.
- iLS_wr  input  1  1 = store, 0 = load.
- iLS_len  input  3  byte count: 1, 2 or 4.
- iLS_addr  input  32  data address.
- iLS_dt  input  32  store data.
- oLS_done  output  1  one-cycle completion pulse.
- oLS_dt  output  32  load data, zero-extended by the controller.
- iPF_req  input  1  prefetch request (4-byte read).
- iPF_addr  input  32  prefetch address.
- oPF_done  output  1  one-cycle prefetch-complete pulse.
- oPF_dt  output  32  prefetched word.
- oMC_en  output  1  controller request, held until iMC_done.
- oMC_wr  output  1  store flag to the controller.
- oMC_len  output  3  byte count to the controller.
- oMC_addr  output  32  address to the controller.
- oMC_dt  output  32  store data to the controller.
- iMC_done  input  1  controller completion pulse.
- iMC_dt  input  32  controller read data.
- oGrant  output  2  current owner: 0 none, 1 IF, 2 LS, 3 PF.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, starve counter 0, every output 0.
- rdy=0: no state, counter or oMC_* update. oX_done registers clear to 0.
- States:
  - IDLE: arbitrate.
  - BUSY: grant held, oMC_en=1.
  - DRAIN: a flushed IF/PF access is still in flight.
- Arbitration, at an IDLE edge with rdy=1; exactly one winner:
  - LS is eligible unless (iLS_wr=1 and iLS_addr >= IO_BASE and iIO_buffer_full=1); a blocked LS stays pending.
  - Default priority is LS > IF > PF.
  - If IF is pending and starve counter == STARVE_LIMIT, IF wins over LS.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each time LS wins while iIF_req=1.
  - Clears when IF wins.
- A win registers oMC_* and oGrant and moves the FSM to BUSY. oMC_en rises the cycle after the request is sampled.
- IF and PF grants drive oMC_wr=0 and oMC_len=4.
- BUSY:
  - Request inputs are ignored.
  - oMC_* hold stable.
  - On iMC_done: registered oX_done=1 and oX_dt=iMC_dt for the owner on the next edge; oMC_en=0; oGrant=0; go to IDLE.
  - Minimum turnaround: a new grant is sampled the edge after return to IDLE.
- Flush:
  - iFlush=1 in IDLE: IF and PF are excluded from that edge's arbitration.
  - iFlush=1 in BUSY with owner IF or PF, and no iMC_done that cycle: go to DRAIN. oMC_en stays 1 until iMC_done.
  - iFlush=1 coincident with iMC_done for owner IF or PF: no done pulse; go to IDLE.
  - In DRAIN, iMC_done returns the FSM to IDLE with no done pulse and no data update.
  - LS accesses are never affected by iFlush.
- oX_dt holds its last value between pulses.
- Done pulses are exactly one cycle.
- iMC_done in IDLE is ignored.

Decomposition:
- Shared package/config holds:
  - owner encodings (None/IF/LS/PF);
  - FSM state encodings (Idle/Busy/Drain);
  - length codes One/Two/Four;
  - IO_BASE.
- One natural sub-module, mem_arb_pick: combinational priority/starvation selector. Inputs are the eligibility flags and starve-saturated flag; output is the winner code. The FSM and counters stay in the top.

Test Plan:
- Single IF: iIF_req=1, addr 0x100; iMC_done after 5 cycles with iMC_dt=0xDEADBEEF -> oMC_en high exactly 5 cycles, oMC_len=4, oIF_done one pulse with oIF_dt=0xDEADBEEF, oGrant back to 0.
- Contention and starvation, STARVE_LIMIT=4: IF and LS held high continuously -> grant order LS, LS, LS, LS, IF, LS...; PF never granted while either is requesting.
- IO back-pressure: LS store to 0x30000 with iIO_buffer_full=1, IF pending -> IF granted. When full drops, LS is granted with oMC_wr=1 and oMC_dt=iLS_dt.
- Flush during fetch: IF in BUSY, iFlush pulse mid-access -> DRAIN, oMC_en held until iMC_done, no oIF_done. Next LS is granted afterwards normally.
- Flush coincident with done, and rdy stall: both give no oIF_done. rdy=0 for 3 cycles in BUSY -> oMC_* unchanged and no duplicate done.
- Async reset mid-BUSY: rst=0 between edges -> all outputs 0 immediately, FSM IDLE; a request after reset release is granted normally.
